// File: rtl/demux_route_ctrl_pkg.sv
// Shared definitions for the demux routing controller: FSM state encoding
// and the default frame format used by the controller and its traffic sources.
package demux_route_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        LEN  = 2'd2,
        PAY  = 2'd3
    } state_t;

    localparam int LEN_W_DEFAULT = 4;

endpackage

// File: rtl/demux_route_ctrl_if.sv
// Serial frame input and demux drive bundle between a traffic source (master)
// and the routing controller (slave).
interface demux_route_ctrl_if;

    logic din;
    logic din_valid;
    logic start;
    logic s0;
    logic s1;
    logic a;
    logic a_valid;
    logic busy;
    logic frame_done;
    logic err;

    modport master (
        output din, din_valid, start,
        input  s0, s1, a, a_valid, busy, frame_done, err
    );

    modport slave (
        input  din, din_valid, start,
        output s0, s1, a, a_valid, busy, frame_done, err
    );

endinterface

// File: rtl/demux_route_ctrl_frame_bit_counter.sv
// Loadable down-counter shared by the length and payload phases of a frame.
// Clear has priority over load, load over decrement; it never wraps below 0.
module demux_route_ctrl_frame_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // Counter register: clear, load or saturating decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/demux_route_ctrl.sv
// Bit-serial frame parser driving a 4-way demux: latches the 2-bit destination
// onto s0/s1 and forwards the payload bits onto a with one cycle of latency.
module demux_route_ctrl
    import demux_route_ctrl_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    demux_route_ctrl_if.slave bus
);

    // One counter covers both the length-bit count (needs clog2(LEN_W)+1 bits)
    // and the payload count (needs LEN_W bits), so it takes the wider of the two.
    localparam int CNT_W = (LEN_W > $clog2(LEN_W) + 1) ? LEN_W : $clog2(LEN_W) + 1;

    state_t             state;
    logic               hdr0;
    logic [LEN_W-1:0]   len_reg;
    logic [LEN_W-1:0]   len_next;
    logic               abort;
    logic               cnt_clr;
    logic               cnt_load;
    logic               cnt_dec;
    logic [CNT_W-1:0]   cnt_load_val;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_zero;
    logic               cnt_last;
    logic               s0_q;
    logic               s1_q;
    logic               a_q;
    logic               a_valid_q;
    logic               frame_done_q;
    logic               err_q;

    assign abort    = bus.din_valid && bus.start && (state != IDLE);
    assign len_next = (len_reg << 1) | LEN_W'(bus.din);
    assign cnt_last = (cnt_val == CNT_W'(1));

    demux_route_ctrl_frame_bit_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    // Counter control: arm with LEN_W at the header, reload with the length
    // on the last length bit, count payload bits down in PAY.
    always_comb begin
        cnt_clr      = abort;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = CNT_W'(LEN_W);
        if (bus.din_valid && !abort) begin
            case (state)
                HDR: cnt_load = 1'b1;
                LEN: begin
                    if (cnt_last && (len_next != '0)) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(len_next);
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                PAY: cnt_dec = 1'b1;
                default: ;
            endcase
        end
    end

    // Frame FSM with registered demux drive and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hdr0         <= 1'b0;
            len_reg      <= '0;
            s0_q         <= 1'b0;
            s1_q         <= 1'b0;
            a_q          <= 1'b0;
            a_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            a_q          <= 1'b0;
            a_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            if (abort) begin
                // A start mid-frame restarts parsing; s0/s1 keep the old route.
                err_q   <= 1'b1;
                state   <= HDR;
                hdr0    <= bus.din;
                len_reg <= '0;
            end else if (bus.din_valid) begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state <= HDR;
                            hdr0  <= bus.din;
                        end
                    end
                    HDR: begin
                        s0_q    <= hdr0;
                        s1_q    <= bus.din;
                        len_reg <= '0;
                        state   <= LEN;
                    end
                    LEN: begin
                        len_reg <= len_next;
                        if (cnt_last) begin
                            if (len_next != '0) begin
                                state <= PAY;
                            end else begin
                                state        <= IDLE;
                                frame_done_q <= 1'b1;
                            end
                        end
                    end
                    PAY: begin
                        a_q       <= bus.din;
                        a_valid_q <= 1'b1;
                        if (cnt_last || cnt_zero) begin
                            state        <= IDLE;
                            frame_done_q <= cnt_last;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.s0         = s0_q;
    assign bus.s1         = s1_q;
    assign bus.a          = a_q;
    assign bus.a_valid    = a_valid_q;
    assign bus.busy       = (state != IDLE);
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Directed bench for demux_route_ctrl: a frame-position model predicts every
// output each cycle, and literal expectations pin the key scenarios.
module tb_demux_route_ctrl;
    import demux_route_ctrl_pkg::*;

    localparam int LW = LEN_W_DEFAULT;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    demux_route_ctrl_if bus();

    demux_route_ctrl #(
        .LEN_W (LW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: position k within the current frame and the length seen so far.
    logic m_in = 1'b0;
    int   m_k = 0;
    logic m_h0 = 1'b0;
    int   m_len = 0;
    logic e_s0 = 1'b0, e_s1 = 1'b0, e_a = 1'b0, e_av = 1'b0;
    logic e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;

    // Monitor results collected at each falling edge.
    logic q_out[$];
    int   n_done = 0;
    int   n_err = 0;

    // Model update on every accepted bit.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_in = 0; m_k = 0; m_h0 = 0; m_len = 0;
            e_s0 = 0; e_s1 = 0; e_a = 0; e_av = 0; e_busy = 0; e_done = 0; e_err = 0;
        end else begin
            e_a = 0; e_av = 0; e_done = 0; e_err = 0;
            if (bus.din_valid) begin
                if (bus.start) begin
                    e_err = m_in;
                    m_in  = 1; m_k = 1; m_h0 = bus.din; m_len = 0;
                end else if (m_in) begin
                    if (m_k == 1) begin
                        e_s0 = m_h0;
                        e_s1 = bus.din;
                    end else if (m_k < 2 + LW) begin
                        m_len = m_len * 2 + (bus.din ? 1 : 0);
                        if (m_k == 1 + LW && m_len == 0) begin
                            e_done = 1; m_in = 0;
                        end
                    end else begin
                        e_a = bus.din; e_av = 1;
                        if (m_k - 2 - LW == m_len - 1) begin
                            e_done = 1; m_in = 0;
                        end
                    end
                    m_k++;
                end
            end
            e_busy = m_in;
        end
    end

    // Per-cycle comparison against the model, plus event collection.
    initial forever begin
        logic [6:0] got, exp;
        @(negedge clk);
        got = {bus.s0, bus.s1, bus.a, bus.a_valid, bus.busy, bus.frame_done, bus.err};
        exp = {e_s0, e_s1, e_a, e_av, e_busy, e_done, e_err};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t {s0,s1,a,a_valid,busy,done,err} got=%b exp=%b", $time, got, exp);
        end
        if (bus.a_valid === 1'b1) q_out.push_back(bus.a);
        if (bus.frame_done === 1'b1) n_done++;
        if (bus.err === 1'b1) n_err++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic send(input logic st, input logic d);
        @(posedge clk); #2;
        bus.din_valid = 1'b1;
        bus.start     = st;
        bus.din       = d;
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            bus.din_valid = 1'b0;
            bus.start     = 1'b0;
            bus.din       = 1'b1;
        end
    endtask

    // Sends bits[n-1] first; the first bit carries start.
    task automatic send_frame(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send(i == n - 1, bits[i]);
    endtask

    task automatic clear_mon();
        q_out.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    function automatic logic [31:0] qpack();
        logic [31:0] v = '0;
        foreach (q_out[i]) v = {v[30:0], q_out[i]};
        return v;
    endfunction

    initial begin
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.start = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_outs", {bus.s0, bus.s1, bus.a, bus.a_valid, bus.busy, bus.frame_done, bus.err}, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Bits without start are dropped in IDLE.
        send(0, 1); send(0, 0); send(0, 1); stall(2);
        chk("idle_drop_busy", bus.busy, 0);

        // Basic frame: dest 3, length 3, payload 1,0,1.
        clear_mon();
        send_frame(9'b110011101, 9);
        stall(1);
        @(negedge clk);
        chk("basic_last_av", bus.a_valid, 1);
        chk("basic_last_a", bus.a, 1);
        chk("basic_last_done", bus.frame_done, 1);
        stall(2);
        chk("basic_nbits", q_out.size(), 3);
        chk("basic_bits", qpack(), 3'b101);
        chk("basic_ndone", n_done, 1);
        chk("basic_sel", {bus.s1, bus.s0}, 2'b11);

        // Same frame with stalls inside LEN and PAY.
        clear_mon();
        send(1, 1); send(0, 1); send(0, 0); stall(2);
        send(0, 0); send(0, 1); send(0, 1);
        send(0, 1); stall(1); send(0, 0); send(0, 1);
        stall(3);
        chk("stall_nbits", q_out.size(), 3);
        chk("stall_bits", qpack(), 3'b101);
        chk("stall_ndone", n_done, 1);

        // Zero length: dest 2 (s1=1, s0=0), no payload.
        clear_mon();
        send_frame(6'b010000, 6);
        stall(1);
        @(negedge clk);
        chk("zero_done", bus.frame_done, 1);
        chk("zero_busy", bus.busy, 0);
        stall(2);
        chk("zero_ndone", n_done, 1);
        chk("zero_nbits", q_out.size(), 0);
        chk("zero_sel", {bus.s1, bus.s0}, 2'b10);

        // Abort in PAY, then a new frame: dest 0, length 1, payload 1.
        clear_mon();
        send_frame(8'b10010111, 8);
        send(1, 0);
        send(0, 0);
        #3;
        chk("abort_err", bus.err, 1);
        chk("abort_av", bus.a_valid, 0);
        chk("abort_sel_hold", {bus.s1, bus.s0}, 2'b01);
        send(0, 0); send(0, 0); send(0, 0); send(0, 1);
        send(0, 1);
        stall(1);
        @(negedge clk);
        chk("abort_new_sel", {bus.s1, bus.s0}, 2'b00);
        chk("abort_new_a", {bus.a_valid, bus.a, bus.frame_done}, 3'b111);
        stall(2);
        chk("abort_nerr", n_err, 1);
        chk("abort_ndone", n_done, 1);
        chk("abort_bits", qpack(), 3'b111);
        chk("abort_nbits", q_out.size(), 3);

        // Back-to-back: A dest 2 len 1 payload 0, then B dest 3 len 2 payload 1,1.
        clear_mon();
        send_frame(7'b0100010, 7);
        send_frame(8'b11001011, 8);
        stall(1);
        @(negedge clk);
        chk("b2b_done", bus.frame_done, 1);
        stall(2);
        chk("b2b_ndone", n_done, 2);
        chk("b2b_nerr", n_err, 0);
        chk("b2b_sel", {bus.s1, bus.s0}, 2'b11);
        chk("b2b_bits", qpack(), 3'b011);
        chk("b2b_nbits", q_out.size(), 3);

        // Asynchronous reset in the middle of a payload.
        send_frame(7'b1100101, 7);
        @(posedge clk);
        #3;
        chk("prereset_av", bus.a_valid, 1);
        rst_n = 1'b0;
        bus.din_valid = 1'b0;
        #1;
        chk("async_reset_outs", {bus.s0, bus.s1, bus.a, bus.a_valid, bus.busy, bus.frame_done, bus.err}, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        clear_mon();
        send(0, 1); send(0, 0); send(0, 1); stall(2);
        chk("post_reset_busy", bus.busy, 0);
        chk("post_reset_ndone", n_done, 0);
        chk("post_reset_nbits", q_out.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_route_ctrl.md
Name: demux_route_ctrl

Overview:
- Serial frame parser that sits directly upstream of the 4-way demux and drives its select lines (s0, s1) and its data line (a).
- Takes a bit-serial frame made of a 2-bit destination header, an LEN_W-bit payload length, and then the payload bits.
- Latches the destination onto s0/s1 and streams the payload onto a, while the demux routes it to one of its four outputs.

Parameters:
- LEN_W, 4, width of the length field; maximum payload is 2^LEN_W-1 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset
- din  input  1  serial frame bit
- din_valid  input  1  din carries a bit this cycle; low means stall
- start  input  1  qualifies din as the first bit of a frame; ignored unless din_valid=1
- s0  output  1  demux select LSB, registered
- s1  output  1  demux select MSB, registered
- a  output  1  demux data, registered; 0 outside payload
- a_valid  output  1  a carries a payload bit this cycle
- busy  output  1  frame in progress (state != IDLE)
- frame_done  output  1  one-cycle pulse, frame completed
- err  output  1  one-cycle pulse, frame aborted by a new start

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All outputs and state are 0 / IDLE on reset.
- Accepted bit: a bit is accepted only when din_valid=1. With din_valid=0, state, counters and s0/s1 hold, and a/a_valid are driven 0.
- FSM states: IDLE, HDR, LEN, PAY.
- IDLE -> HDR: on an accepted bit with start=1. That bit is header bit 0 (becomes s0).
  - Accepted bits with start=0 in IDLE are dropped.
- HDR -> LEN: on the next accepted bit (becomes s1).
  - s0 and s1 update together, registered, in the cycle after that bit is accepted.
  - s0/s1 then hold until the next header completes. Between frames they keep their last value.
- LEN: shifts in LEN_W bits, MSB first, into a length register.
  - On the last length bit with length != 0: go to PAY, payload counter = length.
  - On the last length bit with length == 0: go to IDLE and pulse frame_done in the next cycle. No a_valid is asserted.
- PAY: each accepted bit appears on a with a_valid=1 exactly one cycle later (latency 1) and decrements the counter.
  - When the bit taking the counter to 0 is accepted, go to IDLE.
  - frame_done pulses in the same cycle as the a_valid of the last payload bit.
- Start mid-frame (state != IDLE, accepted bit with start=1):
  - Pulse err next cycle.
  - Discard the current frame; the counter and length are cleared.
  - Treat the bit as header bit 0 of a new frame (state -> HDR).
  - s0/s1 keep their old values until the new header completes.
  - If this occurs in PAY, the bit is not forwarded and a_valid=0.
- Back-to-back frames: a start in the cycle right after the final bit is accepted normally, with no gap required.
- Simultaneous events: frame_done and err are never asserted in the same cycle. An aborting start suppresses frame_done.
- Reset mid-frame: immediate return to IDLE; all outputs go to 0 asynchronously.
- Counter widths:
  - Length shift counter: clog2(LEN_W)+1 bits, so LEN_W=1 is legal.
  - Payload counter: LEN_W bits, no wrap; decrement occurs only in PAY with counter >= 1.

Decomposition:
- Shared package holds:
  - The state encoding constants IDLE=2'd0, HDR=2'd1, LEN=2'd2, PAY=2'd3.
  - The default LEN_W, so that the traffic generator and bench use the same frame format.
- One natural sub-module: frame_bit_counter, a loadable down-counter with load, dec and zero flag. It is shared by the LEN and PAY phases.
- The FSM and output registers stay in the top.

Test Plan:
- Reset and idle: apply rst_n=0 mid-stream -> s0=s1=a=a_valid=busy=0 immediately. Send bits with start=0 after release -> busy stays 0.
- Basic frame, LEN_W=4: send start+bits 1,1 | 0,0,1,1 | 1,0,1 -> s0=1, s1=1 from the cycle after the header. a_valid high for 3 cycles carrying 1,0,1, each one cycle after its input. frame_done coincides with the third a_valid.
- Stall: same frame with din_valid=0 for 2 cycles inside LEN and 1 cycle inside PAY -> identical output sequence, delayed. a_valid=0 during the stall cycle and s0/s1 stable.
- Zero length: header 0,1, length 0000 -> s0=0, s1=1. No a_valid. frame_done pulses once in the cycle after the last length bit. busy=0 afterwards.
- Abort: header 1,0, length 0101, 2 payload bits, then start with bits 0,0 and length 0001, payload 1 -> err pulses once and s0/s1 stay 1,0 until the new header. Then s0=s1=0, a single a_valid with a=1, and frame_done pulses once.
- Back-to-back: frame A (dest 2, len 1) immediately followed by frame B (dest 3, len 2) -> s0/s1 go from 0,1 to 1,1 with no gap. Two frame_done pulses, no err.
